// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the multicycle datapath ALU and its neighbours.
//   - ALU function codes driven on alu32.f
//   - div_state_t : control states of the sequential divider divu32_seq
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

endpackage : alu_pkg

// File: rtl/alu32.sv
// ---------------------------------------------------------------------------
// alu32
//   Combinational 32-bit ALU of the multicycle datapath.
//   Ports:
//     a, b      in  32 : operands
//     f         in  3  : function code (alu_pkg ALU_* values)
//     y         out 32 : result
//     zero      out 1  : y == 0
//     overflow  out 1  : signed overflow of the add/subtract
// ---------------------------------------------------------------------------
module alu32
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  f,
   output logic [31:0] y,
   output logic        zero,
   output logic        overflow
);

   logic [31:0] sum;
   logic [31:0] diff;
   logic        ovf_add;
   logic        ovf_sub;

   assign sum     = a + b;
   assign diff    = a - b;
   assign ovf_add = (a[31] == b[31]) & (sum[31]  != a[31]);
   assign ovf_sub = (a[31] != b[31]) & (diff[31] != a[31]);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // an unlisted function code can never infer a latch.
      y        = '0;
      overflow = 1'b0;
      case (f)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: begin
            y        = sum;
            overflow = ovf_add;
         end
         ALU_SUB: begin
            y        = diff;
            overflow = ovf_sub;
         end
         // Signed less-than: sign of the difference corrected for overflow.
         ALU_SLT: y = {31'b0, diff[31] ^ ovf_sub};
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule : alu32

// File: rtl/divu32_seq.sv
// ---------------------------------------------------------------------------
// divu32_seq
//   Sequential 32-bit unsigned restoring divider, one quotient bit per cycle,
//   using a single alu32 in subtract mode. Divide-by-zero resolves at issue.
//   Ports:
//     clk          in  1  : rising-edge clock
//     reset_n      in  1  : synchronous reset, active-low
//     start        in  1  : issue request, sampled only while ready
//     dividend     in  32 : numerator, captured on accept
//     divisor      in  32 : denominator, captured on accept
//     ready        out 1  : IDLE or DONE
//     busy         out 1  : RUN
//     done         out 1  : one-cycle pulse when results become valid
//     quotient     out 32 : result, held until the next accept
//     remainder    out 32 : result, held until the next accept
//     div_by_zero  out 1  : qualifies the held results
// ---------------------------------------------------------------------------
module divu32_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32  // must stay 32: alu32 is fixed-width
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state, state_next;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] rem_acc;   // partial remainder R
   logic [WIDTH-1:0] quo_acc;   // shifting dividend / quotient Q
   logic [WIDTH-1:0] dvsr;      // latched divisor D

   logic             accept;
   logic             dvsr_zero;
   div_state_t       issue_state;

   logic [WIDTH-1:0] shifted;   // S
   logic [WIDTH-1:0] diff;
   logic             lt;
   logic             sub_ok;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   logic             alu_zero;
   logic             alu_overflow;
   logic             unused_alu_flags;

   // ---------------------------------------------------------------------
   // Control decode (all from the state register)
   // ---------------------------------------------------------------------
   assign ready       = (state == IDLE) || (state == DONE);
   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign accept      = start & ready;
   assign dvsr_zero   = (divisor == '0);
   assign issue_state = dvsr_zero ? DONE : RUN;

   // ---------------------------------------------------------------------
   // Restoring step
   // ---------------------------------------------------------------------
   assign shifted = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};

   alu32 u_alu (
      .a        (shifted),
      .b        (dvsr),
      .f        (ALU_SUB),
      .y        (diff),
      .zero     (alu_zero),
      .overflow (alu_overflow)
   );

   // Only the difference is needed; the flags are intentionally dropped.
   assign unused_alu_flags = alu_zero ^ alu_overflow;

   // Unsigned S < D from the signed-style difference: when the top bits
   // differ the operand with the set MSB is the larger one.
   assign lt = (shifted[WIDTH-1] ^ dvsr[WIDTH-1]) ? dvsr[WIDTH-1] : diff[WIDTH-1];

   // R[31] set means the true 33-bit S is >= 2^32 > D, so the subtraction
   // always succeeds and diff is already correct modulo 2^32.
   assign sub_ok   = rem_acc[WIDTH-1] | ~lt;
   assign rem_step = sub_ok ? diff : shifted;
   assign quo_step = {quo_acc[WIDTH-2:0], sub_ok};

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process ordering.
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = issue_state;
         RUN:     if (cnt == '0) state_next = DONE;
         DONE:    state_next = start ? issue_state : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt         <= '0;
         rem_acc     <= '0;
         quo_acc     <= '0;
         dvsr        <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         dvsr        <= divisor;
         quo_acc     <= dividend;
         rem_acc     <= '0;
         div_by_zero <= 1'b0;
         if (dvsr_zero) begin
            cnt         <= '0;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            cnt <= 5'd31;
         end
      end else if (state == RUN) begin
         rem_acc <= rem_step;
         quo_acc <= quo_step;
         if (cnt == '0) begin
            quotient  <= quo_step;
            remainder <= rem_step;
         end else begin
            cnt <= cnt - 5'd1;
         end
      end
   end

endmodule : divu32_seq

// File: tb/tb_divu32_seq.sv
// ---------------------------------------------------------------------------
// tb_divu32_seq
//   Directed bench for divu32_seq. Stimulus pushes hand-computed results into
//   a scoreboard queue; an independent monitor pops and compares on done.
// ---------------------------------------------------------------------------
module tb_divu32_seq;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        ready, busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   divu32_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp_v);
      end
   endtask

   // Monitor: compares results whenever the DUT presents done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
               e = sb.pop_front();
               check({e.name, " quotient"},  quotient,  e.q);
               check({e.name, " remainder"}, remainder, e.r);
               check({e.name, " dbz"},       {31'b0, div_by_zero}, {31'b0, e.dbz});
            end
         end
      end
   end

   // Called at a negedge; start is seen at the following posedge (edge k).
   // Returns at the negedge of the cycle after edge k.
   task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input bit expect_result,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                        input string nm);
      exp_t e;
      check({nm, " ready_at_issue"}, {31'b0, ready}, 32'd1);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      if (expect_result) begin
         e.q = eq; e.r = er; e.dbz = edbz; e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // lat0: cycles after edge k already elapsed (1 = cycle right after edge k).
   // Returns at the negedge of the done cycle.
   task automatic wait_done(input string nm, input int lat0, input int exp_lat);
      int lat   = lat0;
      int nbusy = 0;
      while (!done && lat < 200) begin
         if (busy) nbusy++;
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, lat, exp_lat);
      check({nm, " busy_cycles"}, nbusy, exp_lat - lat0);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, " ready"},     {31'b0, ready}, 32'd1);
      check({nm, " busy"},      {31'b0, busy},  32'd0);
      check({nm, " done"},      {31'b0, done},  32'd0);
      check({nm, " quotient"},  quotient,  32'd0);
      check({nm, " remainder"}, remainder, 32'd0);
      check({nm, " dbz"},       {31'b0, div_by_zero}, 32'd0);
   endtask

   initial begin
      int ndone;

      // Power-on reset
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset_n = 1'b1;
      @(negedge clk);

      // 100 / 7 from IDLE
      issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, "100/7");
      wait_done("100/7", 1, 33);
      @(negedge clk);
      check("100/7 done_pulse_width", {31'b0, done}, 32'd0);
      check("100/7 ready_after", {31'b0, ready}, 32'd1);
      check("100/7 held_quotient", quotient, 32'd14);

      // R[31] path, then back-to-back issues in the DONE cycle
      issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd1, 32'h7FFF_FFFF, 1'b0, "ffffffff/80000000");
      wait_done("ffffffff/80000000", 1, 33);
      issue(32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, "ffffffff/1");
      wait_done("ffffffff/1", 1, 33);
      issue(32'h1234_5678, 32'h0000_1000, 1'b1, 32'h0001_2345, 32'h0000_0678, 1'b0, "12345678/1000");
      wait_done("12345678/1000", 1, 33);
      @(negedge clk);

      // Divide-by-zero, then a normal divide clears the flag
      issue(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, "5/0");
      wait_done("5/0", 1, 1);
      issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, "9/3");
      check("9/3 dbz_cleared_at_accept", {31'b0, div_by_zero}, 32'd0);
      check("9/3 busy_after_accept", {31'b0, busy}, 32'd1);
      wait_done("9/3", 1, 33);
      repeat (2) @(negedge clk);

      // start while busy is ignored
      issue(32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, "1000/3");
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_done("1000/3", 4, 33);

      // start held in the DONE cycle is accepted
      issue(32'd7, 32'd7, 1'b1, 32'd1, 32'd0, 1'b0, "7/7");
      wait_done("7/7", 1, 33);
      repeat (2) @(negedge clk);

      // Reset mid-RUN aborts without a done pulse
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, "abort");
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_reset_outputs("abort");
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort no_done", ndone, 0);

      issue(32'd0, 32'd3, 1'b1, 32'd0, 32'd0, 1'b0, "0/3");
      wait_done("0/3", 1, 33);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_divu32_seq
